// File: rtl/pmem_burst_responder_if.sv
// Four-beat 64-bit physical-memory burst bus between the cacheline adapter (master)
// and the memory responder (slave). pmem_err exists only when PMEM_BURST_CHECK_EN is defined.
interface pmem_burst_responder_if;
  // Handshake: the master raises pmem_read or pmem_write with a stable pmem_address and
  // holds it until the 4th pmem_resp beat; each cycle with pmem_resp high transfers one
  // beat (pmem_rdata valid for reads, pmem_wdata consumed for writes), and the master
  // advances pmem_wdata only after a resp cycle.
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
`ifdef PMEM_BURST_CHECK_EN
  logic        pmem_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp, pmem_err
  );
  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp, pmem_err
  );
`else
  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
`endif
endinterface

// File: rtl/pmem_burst_responder.sv
// Line-granular memory responder: programmable latency, then four 64-bit beats per request.
// Optional sticky protocol checker enabled by defining PMEM_BURST_CHECK_EN.
module pmem_burst_responder #(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pmem_burst_responder_if.slave  bus,
  output logic [1:0]             dbg_state
);

  localparam int L  = $clog2(DEPTH_LINES);
  localparam int AW = L + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_e;

  state_e         state_q, state_d;
  logic           op_q, op_d;           // 1 = write
  logic [L-1:0]   index_q, index_d;
  logic [3:0]     lat_cnt_q, lat_cnt_d;
  logic [1:0]     beat_q, beat_d;
  logic [63:0]    rdata_q;
  logic           mem_we, mem_re;
  logic [AW-1:0]  mem_addr;
  logic [63:0]    mem [DEPTH_LINES*4];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.pmem_address[4:0], bus.pmem_address[31:5+L]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    index_d   = index_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    case (state_q)
      S_IDLE: begin
        if (bus.pmem_read || bus.pmem_write) begin
          op_d      = bus.pmem_write;
          index_d   = bus.pmem_address[5+L-1:5];
          lat_cnt_d = 4'(LATENCY - 1);
          beat_d    = 2'd0;
          state_d   = (LATENCY > 1) ? S_WAIT : S_BURST;
        end
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) state_d = S_BURST;
      end
      S_BURST: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reads are issued one cycle early using next-state values so rdata_q lines up with resp.
  always_comb begin
    mem_we   = (state_q == S_BURST) && op_q && !rst;
    mem_re   = (state_d == S_BURST) && !op_d;
    mem_addr = mem_we ? {index_q, beat_q} : {index_d, beat_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      index_q   <= '0;
      lat_cnt_q <= 4'd0;
      beat_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      index_q   <= index_d;
      lat_cnt_q <= lat_cnt_d;
      beat_q    <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= bus.pmem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)         rdata_q <= '0;
    else if (mem_re) rdata_q <= mem[mem_addr];
    else             rdata_q <= '0;
  end

  assign bus.pmem_resp  = (state_q == S_BURST);
  assign bus.pmem_rdata = rdata_q;
  assign dbg_state      = state_q;

`ifdef PMEM_BURST_CHECK_EN
  logic [26:0] tag_q, tag_d;
  logic        err_q, err_d;

  always_comb begin
    tag_d = tag_q;
    err_d = err_q;
    if (state_q == S_IDLE && (bus.pmem_read || bus.pmem_write)) begin
      tag_d = bus.pmem_address[31:5];
      if (bus.pmem_read && bus.pmem_write) err_d = 1'b1;
    end
    if (state_q == S_WAIT || state_q == S_BURST) begin
      if (bus.pmem_address[31:5] != tag_q)          err_d = 1'b1;
      if (op_q ? !bus.pmem_write : !bus.pmem_read)  err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      err_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      err_q <= err_d;
    end
  end

  assign bus.pmem_err = err_q;
`endif

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed bench for pmem_burst_responder: main instance at LATENCY 4 plus LATENCY 1 and 15
// instances for timing. Build with PMEM_BURST_CHECK_EN defined to also check pmem_err.
module tb_pmem_burst_responder;

  localparam int LAT = 4;

  logic clk;
  logic rst;
  logic [1:0] dbg0, dbg1, dbg15;
  int checks;
  int errors;

  pmem_burst_responder_if bus();
  pmem_burst_responder_if l1_bus();
  pmem_burst_responder_if l15_bus();

  pmem_burst_responder #(.DEPTH_LINES(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg0)
  );
  pmem_burst_responder #(.DEPTH_LINES(256), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .bus(l1_bus), .dbg_state(dbg1)
  );
  pmem_burst_responder #(.DEPTH_LINES(256), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .bus(l15_bus), .dbg_state(dbg15)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete burst on the main instance, starting at a negedge in IDLE.
  // Returns at the negedge of cycle LAT+5 (IDLE again).
  task automatic do_burst(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [255:0] wline,
                          output logic [255:0] rline);
    int first;
    int nresp;
    first = -1;
    nresp = 0;
    rline = '0;
    bus.pmem_read    = rd;
    bus.pmem_write   = wr;
    bus.pmem_address = addr;
    bus.pmem_wdata   = wline[63:0];
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge clk);
      if (bus.pmem_resp) begin
        if (first < 0) first = k;
        if (nresp < 4) begin
          rline[64*nresp +: 64] = bus.pmem_rdata;
          bus.pmem_wdata = wline[64*nresp +: 64];
        end
        nresp++;
      end
    end
    check({tag, "_first_resp"}, 256'(first), 256'(LAT));
    check({tag, "_resp_count"}, 256'(nresp), 256'd4);
    check({tag, "_done_rdata"}, 256'(bus.pmem_rdata), 256'd0);
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    @(negedge clk);
  endtask

  // driver + scoreboard
  initial begin
    logic [255:0] rl;
    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] line_aa;
    logic [31:0]  pat;
    logic [31:0]  pat1;
    logic [31:0]  pat15;
    logic [255:0] exp_q[$];

    checks = 0;
    errors = 0;
    line_a  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_b  = {64'hA4A4_A4A4_0000_0004, 64'hA3A3_A3A3_0000_0003,
               64'hA2A2_A2A2_0000_0002, 64'hA1A1_A1A1_0000_0001};
    line_aa = {4{64'hAAAA_AAAA_AAAA_AAAA}};

    rst = 1'b1;
    bus.pmem_read = 1'b1;
    bus.pmem_write = 1'b0;
    bus.pmem_address = 32'h0000_0040;
    bus.pmem_wdata = '0;
    l1_bus.pmem_read = 1'b0;
    l1_bus.pmem_write = 1'b0;
    l1_bus.pmem_address = 32'h0;
    l1_bus.pmem_wdata = '0;
    l15_bus.pmem_read = 1'b0;
    l15_bus.pmem_write = 1'b0;
    l15_bus.pmem_address = 32'h0;
    l15_bus.pmem_wdata = '0;

    // Reset held two cycles with a read pending
    @(negedge clk);
    check("rst_resp_c1", 256'(bus.pmem_resp), 256'd0);
    check("rst_rdata_c1", 256'(bus.pmem_rdata), 256'd0);
    @(negedge clk);
    check("rst_resp_c2", 256'(bus.pmem_resp), 256'd0);
    check("rst_rdata_c2", 256'(bus.pmem_rdata), 256'd0);
    check("rst_state", 256'(dbg0), 256'd0);
    rst = 1'b0;
    do_burst("post_rst_read", 1'b1, 1'b0, 32'h0000_0040, '0, rl);

    // Write then read the same line
    do_burst("wr_40", 1'b0, 1'b1, 32'h0000_0040, line_a, rl);
    exp_q.push_back(line_a);
    do_burst("rd_40", 1'b1, 1'b0, 32'h0000_0040, '0, rl);
    check("rd_40_data", rl, exp_q.pop_front());

    // Aliasing: 0x2040 maps onto line 2, low five bits ignored
    do_burst("wr_2040", 1'b0, 1'b1, 32'h0000_2040, line_b, rl);
    exp_q.push_back(line_b);
    exp_q.push_back(line_b);
    do_burst("rd_40_alias", 1'b1, 1'b0, 32'h0000_0040, '0, rl);
    check("alias_data", rl, exp_q.pop_front());
    do_burst("rd_5f_alias", 1'b1, 1'b0, 32'h0000_005F, '0, rl);
    check("alias_low_bits_data", rl, exp_q.pop_front());

    // Simultaneous read+write is a write
    do_burst("rw_80", 1'b1, 1'b1, 32'h0000_0080, line_aa, rl);
`ifdef PMEM_BURST_CHECK_EN
    check("err_after_rw", 256'(bus.pmem_err), 256'd1);
`endif
    exp_q.push_back(line_aa);
    do_burst("rd_80", 1'b1, 1'b0, 32'h0000_0080, '0, rl);
    check("rw_80_data", rl, exp_q.pop_front());
`ifdef PMEM_BURST_CHECK_EN
    check("err_sticky", 256'(bus.pmem_err), 256'd1);
`endif

    // Reset in the beat-2 cycle of a write: beats 0 and 1 stay committed
    do_burst("wr_c0_zero", 1'b0, 1'b1, 32'h0000_00C0, '0, rl);
    bus.pmem_write   = 1'b1;
    bus.pmem_address = 32'h0000_00C0;
    bus.pmem_wdata   = 64'h5555_5555_5555_5555;
    pat = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      pat[k] = bus.pmem_resp;
    end
    check("abort_resp_pattern", 256'(pat), 256'h70);
    rst = 1'b1;
    @(negedge clk);
    check("abort_resp_after_rst", 256'(bus.pmem_resp), 256'd0);
    check("abort_state_after_rst", 256'(dbg0), 256'd0);
    check("abort_rdata_after_rst", 256'(bus.pmem_rdata), 256'd0);
`ifdef PMEM_BURST_CHECK_EN
    check("err_cleared_by_rst", 256'(bus.pmem_err), 256'd0);
`endif
    rst = 1'b0;
    bus.pmem_write = 1'b0;
    @(negedge clk);
    exp_q.push_back({64'd0, 64'd0, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555});
    do_burst("rd_c0_abort", 1'b1, 1'b0, 32'h0000_00C0, '0, rl);
    check("abort_data", rl, exp_q.pop_front());

    // Latency sweep: LATENCY 1 held for two bursts, LATENCY 15 for one
    l1_bus.pmem_read     = 1'b1;
    l1_bus.pmem_address  = 32'h0000_0100;
    l15_bus.pmem_read    = 1'b1;
    l15_bus.pmem_address = 32'h0000_0100;
    pat1  = '0;
    pat15 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      pat1[k]  = l1_bus.pmem_resp;
      pat15[k] = l15_bus.pmem_resp;
      if (k == 11) l1_bus.pmem_read = 1'b0;
      if (k == 19) l15_bus.pmem_read = 1'b0;
    end
    check("lat1_resp_pattern", 256'(pat1), 256'h79E);
    check("lat15_resp_pattern", 256'(pat15), 256'h7_8000);
    check("lat15_idle_state", 256'(dbg15), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmem_burst_responder.md
# pmem_burst_responder

Synthesizable physical-memory responder that terminates the 64-bit, four-beat burst interface driven by the cacheline adapter (pmem_read / pmem_write / pmem_address / pmem_wdata / pmem_rdata / pmem_resp). It stores whole 256-bit lines in an internal 64-bit-wide RAM. It inserts a programmable initial latency, then streams or accepts exactly four beats per request. It sits below the mp4 top level, standing in for DRAM in FPGA builds and in full-system benches.

## Interface
- DEPTH_LINES, 256: number of 256-bit lines stored; power of two, at least 2.
- LATENCY, 4: cycles from request sample to first resp beat; range 1..15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pmem_read  in  1  line read request; held high by the initiator until the 4th resp beat.
- pmem_write  in  1  line write request; held high until the 4th resp beat.
- pmem_address  in  32  line address; bits [4:0] ignored; held stable for the whole burst.
- pmem_wdata  in  64  write beat; the initiator presents beat i and advances after each resp cycle.
- pmem_resp  out  1  high for exactly 4 consecutive cycles per request, once per beat.
- pmem_rdata  out  64  read beat, valid while pmem_resp is high; 0 otherwise.
- pmem_err  out  1  present only with PMEM_BURST_CHECK_EN; sticky protocol-error flag.

## Operation
- Storage: DEPTH_LINES×4 words of 64 bits, single port.
  - Word index = {pmem_address[5+L-1:5], beat[1:0]}, where L = log2(DEPTH_LINES).
  - Address bits above 5+L-1 are ignored, so addresses alias modulo the memory size.
  - Beat 0 holds line bits [63:0]; beat 3 holds [255:192].
- State machine: IDLE, WAIT, BURST, DONE.
- IDLE:
  - Request is sampled when pmem_read or pmem_write is high.
  - Latch op and the line index, load lat_cnt = LATENCY-1, clear beat = 0.
  - Go to WAIT if LATENCY > 1, else go straight to BURST.
  - If read and write are both high, the request is a write (write has priority).
- WAIT: decrement lat_cnt; on lat_cnt == 0 the next state is BURST.
- BURST:
  - pmem_resp = 1 every cycle.
  - Read: pmem_rdata = mem[index, beat].
  - Write: mem[index, beat] <= pmem_wdata at the clock edge ending the cycle.
  - beat increments each cycle; after beat 3 go to DONE.
- DONE: one cycle with pmem_resp = 0. New requests are ignored here, which lets the initiator deassert. Return to IDLE.
- The latched op and index are used for the whole burst; input changes mid-burst have no effect on the transfer.
- Read data is produced by a synchronous RAM read issued one cycle ahead (pipelined) so it lines up with the resp cycle; no combinational RAM-to-output path.

## Timing
- Reset: state IDLE, pmem_resp = 0, pmem_rdata = 0, lat_cnt = 0, beat = 0, pmem_err = 0.
  - RAM contents are not cleared.
  - Reset mid-burst aborts the burst; beats already written stay committed.
- Request sampled in cycle 0 (IDLE). pmem_resp is high in cycles LATENCY through LATENCY+3. Cycle LATENCY+4 is DONE.
- Earliest next request sample is cycle LATENCY+5.
  - Back-to-back bursts therefore cost LATENCY+5 cycles each.
- Read-after-write to the same line returns the new data; the single port serializes the two bursts.
- Request held low → no pmem_resp ever; the block idles indefinitely.

## Configuration
- PMEM_BURST_CHECK_EN defined:
  - pmem_err output exists.
  - It sets in the cycle after any of these: read and write high together when sampled; pmem_address[31:5] differing from the latched value during WAIT/BURST; request dropped before the 4th beat.
  - It is sticky until rst.
- Not defined: the port and all checking logic are absent; behaviour is otherwise identical.

## Test plan
- Reset: hold rst 2 cycles with pmem_read = 1 → pmem_resp = 0 and pmem_rdata = 0 throughout; the first resp appears LATENCY cycles after rst falls.
- Write then read: write line 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read 0x0000_0040 → same four beats in order; resp high exactly 4 cycles each burst, starting in cycle LATENCY (4).
- Latency sweep: LATENCY = 1 and LATENCY = 15 → first resp in cycle 1 and cycle 15 after the request sample; DONE gap of 1 cycle observed.
- Aliasing: DEPTH_LINES = 256, write 0x0000_2040, read 0x0000_0040 → identical data; bits [4:0] = 0x1F on the read give the same result.
- Simultaneous read+write at 0x80 with wdata 0xAA..AA → treated as a write; a later read returns 0xAA..AA. With PMEM_BURST_CHECK_EN, pmem_err = 1 from the next cycle until rst.
- Reset mid-burst: assert rst after beat 1 of a write of 0x55..55 to a line preloaded with zeros → read returns 0x55.., 0x55.., 0, 0; pmem_resp is low the cycle after rst.
